// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: serializes IFU reads and LSU reads/writes onto
// a single memory port, one outstanding transaction at a time, with
// round-robin tie-breaking between the requesters.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,

  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  state_t              state, state_nxt;
  owner_t              last_grant;
  owner_t              owner;
  owner_t              grant;
  logic                hs;

  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [7:0]          wmask_q;

  // Grant selection: a lone requester wins; a tie (or no request at all)
  // goes to LSU unless LSU was the last one served.
  always_comb begin
    grant = OWN_LSU;
    if (ifu_req_valid && !lsu_req_valid) begin
      grant = OWN_IFU;
    end else if (lsu_req_valid && !ifu_req_valid) begin
      grant = OWN_LSU;
    end else if (last_grant == OWN_LSU) begin
      grant = OWN_IFU;
    end
  end

  // Handshake only in IDLE and never while reset is held.
  always_comb begin
    hs = 1'b0;
    if (!rst && state == S_IDLE) begin
      hs = (grant == OWN_LSU) ? lsu_req_valid : ifu_req_valid;
    end
  end

  // State register, grant history and latched request fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= OWN_IFU;
      owner      <= OWN_IFU;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        owner      <= grant;
        last_grant <= grant;
        if (grant == OWN_LSU) begin
          addr_q  <= lsu_addr;
          wen_q   <= lsu_wen;
          wdata_q <= lsu_wdata;
          wmask_q <= lsu_wmask;
        end else begin
          addr_q  <= ifu_addr;
          wen_q   <= 1'b0;
          wdata_q <= '0;
          wmask_q <= '0;
        end
      end
    end
  end

  // Next-state and output decode; every output is forced low while reset is
  // held, even though the state register only clears on the following edge.
  always_comb begin
    state_nxt      = state;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    mem_req_valid  = 1'b0;
    mem_addr       = '0;
    mem_wen        = 1'b0;
    mem_wdata      = '0;
    mem_wmask      = '0;
    ifu_rdata      = '0;
    lsu_rdata      = '0;
    busy           = 1'b0;

    case (state)
      S_IDLE: begin
        if (hs) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (mem_resp_valid) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (!rst) begin
      busy      = (state != S_IDLE);
      ifu_rdata = mem_rdata;
      lsu_rdata = mem_rdata;
      mem_addr  = addr_q;
      mem_wen   = wen_q;
      mem_wdata = wdata_q;
      mem_wmask = wmask_q;
      if (state == S_IDLE) begin
        ifu_req_ready = (grant == OWN_IFU);
        lsu_req_ready = (grant == OWN_LSU);
      end
      if (state == S_REQ) begin
        mem_req_valid = 1'b1;
      end
      if (state == S_RESP && mem_resp_valid) begin
        ifu_resp_valid = (owner == OWN_IFU);
        lsu_resp_valid = (owner == OWN_LSU);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Inputs are driven 1ns after
// the rising edge; outputs are sampled on the falling edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // One full transaction with both readies checked at the grant cycle, the
  // memory address checked in REQ, and the response routed to the owner.
  task automatic run_txn(input string tag, input logic exp_lsu,
                         input logic [31:0] exp_addr, input logic [31:0] rdata);
    sample();
    check({tag, "_lsu_rdy"}, lsu_req_ready, exp_lsu);
    check({tag, "_ifu_rdy"}, ifu_req_ready, !exp_lsu);
    tick();
    mem_req_ready = 1'b1;
    sample();
    check({tag, "_mreqv"}, mem_req_valid, 1'b1);
    check({tag, "_maddr"}, mem_addr, exp_addr);
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = rdata;
    sample();
    check({tag, "_lsu_rv"}, lsu_resp_valid, exp_lsu);
    check({tag, "_ifu_rv"}, ifu_resp_valid, !exp_lsu);
    tick();
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0;
    lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;

    // Reset state
    tick(); tick();
    sample();
    check("rst_ifu_rdy", ifu_req_ready, 1'b0);
    check("rst_lsu_rdy", lsu_req_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_mreqv", mem_req_valid, 1'b0);
    check("rst_maddr", mem_addr, 32'h0);
    check("rst_mwmask", mem_wmask, 8'h0);
    tick();
    rst = 1'b0;
    sample();
    check("idle_tie_lsu", lsu_req_ready, 1'b1);
    check("idle_tie_ifu", ifu_req_ready, 1'b0);

    // LSU write
    tick();
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
    sample();
    check("wr_rdy", lsu_req_ready, 1'b1);
    tick();
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b1;
    sample();
    check("wr_mreqv", mem_req_valid, 1'b1);
    check("wr_maddr", mem_addr, 32'h8000_1000);
    check("wr_mwen", mem_wen, 1'b1);
    check("wr_mwdata", mem_wdata, 32'hDEAD_BEEF);
    check("wr_mwmask", mem_wmask, 8'h0F);
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
    sample();
    check("wr_lsu_rv", lsu_resp_valid, 1'b1);
    check("wr_ifu_rv", ifu_resp_valid, 1'b0);
    tick();
    mem_resp_valid = 1'b0;
    sample();
    check("wr_rv_pulse", lsu_resp_valid, 1'b0);
    check("after_lsu_tie_ifu", ifu_req_ready, 1'b1);

    // Single IFU read
    tick();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    sample();
    check("rd_rdy", ifu_req_ready, 1'b1);
    check("rd_busy0", busy, 1'b0);
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    sample();
    check("rd_busy1", busy, 1'b1);
    check("rd_maddr", mem_addr, 32'h8000_0000);
    check("rd_mwen", mem_wen, 1'b0);
    check("rd_mwmask", mem_wmask, 8'h00);
    check("rd_mwdata", mem_wdata, 32'h0);
    check("rd_rdy_busy", {ifu_req_ready, lsu_req_ready}, 2'b00);
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413;
    sample();
    check("rd_busy2", busy, 1'b1);
    check("rd_ifu_rv", ifu_resp_valid, 1'b1);
    check("rd_ifu_rdata", ifu_rdata, 32'h0000_0413);
    check("rd_lsu_rv", lsu_resp_valid, 1'b0);
    tick();
    mem_resp_valid = 1'b0;
    sample();
    check("rd_busy3", busy, 1'b0);
    check("rd_rv_pulse", ifu_resp_valid, 1'b0);

    // Simultaneous requests, both held valid
    tick();
    ifu_req_valid = 1'b1; ifu_addr = 32'h0000_1000;
    lsu_req_valid = 1'b1; lsu_addr = 32'h0000_2000;
    run_txn("rr0", 1'b1, 32'h0000_2000, 32'h11);
    run_txn("rr1", 1'b0, 32'h0000_1000, 32'h22);
    run_txn("rr2", 1'b1, 32'h0000_2000, 32'h33);
    run_txn("rr3", 1'b0, 32'h0000_1000, 32'h44);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

    // Memory stalls: LSU read, IFU waiting throughout
    lsu_req_valid = 1'b1; lsu_addr = 32'h0000_3000; lsu_wen = 1'b0;
    lsu_wmask = 8'hA5; lsu_wdata = 32'h1234_5678;
    sample();
    check("st_rdy", lsu_req_ready, 1'b1);
    tick();
    lsu_req_valid = 1'b0; lsu_addr = 32'hFFFF_FFFF; ifu_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("st_req_mreqv", mem_req_valid, 1'b1);
      check("st_req_fields", {mem_addr, mem_wmask, mem_wen},
            {32'h0000_3000, 8'hA5, 1'b0});
      check("st_req_rdy", {ifu_req_ready, lsu_req_ready}, 2'b00);
      tick();
    end
    mem_req_ready = 1'b1;
    sample();
    check("st_wdata", mem_wdata, 32'h1234_5678);
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      check("st_resp_wait", {ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 3'b000);
      check("st_resp_rdy", {ifu_req_ready, lsu_req_ready, busy}, 3'b001);
      tick();
    end
    mem_resp_valid = 1'b1;
    sample();
    check("st_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b01);
    tick();
    mem_resp_valid = 1'b0;
    // IFU is granted in IDLE but withdraws before the edge
    sample();
    check("drop_rdy", ifu_req_ready, 1'b1);
    ifu_req_valid = 1'b0;
    tick();
    sample();
    check("drop_no_txn", {busy, mem_req_valid}, 2'b00);

    // Spurious response in IDLE
    tick();
    mem_resp_valid = 1'b1;
    sample();
    check("sp_idle_rv", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    tick();
    mem_resp_valid = 1'b0;
    sample();
    check("sp_idle_busy", busy, 1'b0);
    // Spurious response in REQ
    ifu_req_valid = 1'b1; ifu_addr = 32'h0000_4000;
    tick();
    ifu_req_valid = 1'b0; mem_resp_valid = 1'b1;
    sample();
    check("sp_req_rv", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    tick();
    mem_resp_valid = 1'b0;
    sample();
    check("sp_req_hold", mem_req_valid, 1'b1);
    tick();
    mem_req_ready = 1'b1;
    sample();
    check("sp_req_still", mem_req_valid, 1'b1);
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
    sample();
    check("sp_final_rv", {ifu_resp_valid, lsu_resp_valid}, 2'b10);
    tick();
    mem_resp_valid = 1'b0;

    // Reset while in RESP (last grant LSU before reset)
    lsu_req_valid = 1'b1; lsu_addr = 32'h0000_5000;
    tick();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    sample();
    check("mr_in_resp", busy, 1'b1);
    rst = 1'b1;
    sample();
    check("mr_rst_out", {busy, ifu_req_ready, lsu_req_ready, mem_req_valid}, 4'b0000);
    tick();
    rst = 1'b0; mem_resp_valid = 1'b1;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    sample();
    check("mr_stale_rv", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    check("mr_idle", busy, 1'b0);
    check("mr_tie_lsu", {ifu_req_ready, lsu_req_ready}, 2'b01);
    tick();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_resp_valid = 1'b0;
    sample();
    check("mr_new_req", mem_addr, 32'h0000_5000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
